// File: rtl/operand_stage.sv
// Operand-fetch stage: drives register-file read addresses, resolves rs1/rs2
// through EX/MEM bypasses, detects load-use hazards and inserts a bubble, and
// registers the result into the ID/EX register under a valid/ready handshake.
module operand_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    output logic [4:0]       rf_a1,
    output logic [4:0]       rf_a2,
    input  logic [XLEN-1:0]  rf_rd1,
    input  logic [XLEN-1:0]  rf_rd2,
    input  logic [XLEN-1:0]  ex_result,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [XLEN-1:0]  mem_result,
    input  logic             flush,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_op1,
    output logic [XLEN-1:0]  ex_op2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic [CNT_W-1:0] stall_cnt
);

    // Register-file addresses come straight from decode, no gating.
    assign rf_a1 = id_rs1;
    assign rf_a2 = id_rs2;

    logic [1:0][4:0]      src_idx;
    logic [1:0][XLEN-1:0] src_rf;
    logic [1:0][XLEN-1:0] src_op;
    logic [1:0]           src_use;
    logic [1:0]           src_hz;

    assign src_idx = {id_rs2, id_rs1};
    assign src_rf  = {rf_rd2, rf_rd1};
    assign src_use = {id_use_rs2, id_use_rs1};

    // A load in EX has no result yet, so it never bypasses; it raises a hazard instead.
    logic ex_fwd_ok;
    assign ex_fwd_ok = ex_valid & ex_reg_write & ~ex_mem_read;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            // x0 first, then the younger EX value, then MEM, then the register file.
            assign src_op[gi] = (src_idx[gi] == 5'd0)                         ? '0 :
                                (ex_fwd_ok && ex_rd == src_idx[gi])            ? ex_result :
                                (mem_reg_write && mem_rd == src_idx[gi])       ? mem_result :
                                                                                 src_rf[gi];
            assign src_hz[gi] = src_use[gi] & (src_idx[gi] == ex_rd);
        end
    endgenerate

    logic hz;
    logic adv;

    assign hz       = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) & (|src_hz);
    assign adv      = ~ex_valid | ex_ready;
    assign id_ready = flush | (adv & ~hz);

    // ID/EX pipeline register: flush beats bubble beats load beats drain beats hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_op1       <= '0;
            ex_op2       <= '0;
            ex_imm       <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (adv && hz) begin
            ex_valid <= 1'b0;
        end else if (adv && id_valid) begin
            ex_valid     <= 1'b1;
            ex_pc        <= id_pc;
            ex_op1       <= src_op[0];
            ex_op2       <= src_op[1];
            ex_imm       <= id_imm;
            ex_rd        <= id_rd;
            ex_reg_write <= id_reg_write;
            ex_mem_read  <= id_mem_read;
        end else if (adv) begin
            ex_valid <= 1'b0;
        end
    end

    // Saturating count of load-use bubbles actually inserted (a flush suppresses them).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!flush && adv && hz && stall_cnt != {CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: bypass selection, x0, load-use bubble,
// backpressure, flush, stall counter saturation and asynchronous reset.
module tb_operand_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic             id_ready;
    logic [XLEN-1:0]  id_pc;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_use_rs1, id_use_rs2;
    logic [XLEN-1:0]  id_imm;
    logic             id_reg_write, id_mem_read;
    logic [4:0]       rf_a1, rf_a2;
    logic [XLEN-1:0]  rf_rd1, rf_rd2;
    logic [XLEN-1:0]  ex_result;
    logic [4:0]       mem_rd;
    logic             mem_reg_write;
    logic [XLEN-1:0]  mem_result;
    logic             flush;
    logic             ex_valid;
    logic             ex_ready;
    logic [XLEN-1:0]  ex_pc, ex_op1, ex_op2, ex_imm;
    logic [4:0]       ex_rd;
    logic             ex_reg_write, ex_mem_read;
    logic [CNT_W-1:0] stall_cnt;

    int n_vec;
    int n_err;
    int exp_cnt;

    operand_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .ex_result(ex_result), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_result(mem_result), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_imm = '0; id_reg_write = 0; id_mem_read = 0;
        rf_rd1 = '0; rf_rd2 = '0; ex_result = '0; mem_rd = '0; mem_reg_write = 0;
        mem_result = '0; flush = 0; ex_ready = 1;
    endtask

    task automatic issue(input logic [XLEN-1:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic [XLEN-1:0] imm, input logic rw, input logic mr);
        id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; id_imm = imm; id_reg_write = rw; id_mem_read = mr;
        $display("issue pc=0x%0h rs1=%0d rs2=%0d rd=%0d load=%0d", pc, rs1, rs2, rd, mr);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 0;
        idle();
        #1;
        check("rst_valid", ex_valid, 0);
        check("rst_cnt", stall_cnt, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1;

        // Plain accept: fields appear one edge later
        issue(32'h100, 5'd0, 5'd0, 5'd1, 0, 0, 32'h11, 1, 0);
        step();
        check("a_valid", ex_valid, 1);
        check("a_pc", ex_pc, 32'h100);
        check("a_rd", ex_rd, 1);
        check("a_imm", ex_imm, 32'h11);
        check("a_rw", ex_reg_write, 1);
        check("a_mr", ex_mem_read, 0);

        // EX bypass over register file
        issue(32'h104, 5'd1, 5'd0, 5'd4, 1, 0, 32'h0, 1, 0);
        rf_rd1 = 32'hAAAA; ex_result = 32'h5;
        #1;
        check("b_ready", id_ready, 1);
        check("b_rf_a1", rf_a1, 1);
        step();
        check("b_op1", ex_op1, 32'h5);
        check("b_pc", ex_pc, 32'h104);

        // MEM bypass on rs2
        issue(32'h108, 5'd0, 5'd2, 5'd5, 0, 1, 32'h0, 1, 0);
        mem_rd = 5'd2; mem_reg_write = 1; mem_result = 32'h1234; rf_rd2 = 32'h7777; ex_result = 32'h99;
        step();
        check("c_op2", ex_op2, 32'h1234);

        // x0 reads zero even when MEM targets x0
        issue(32'h10C, 5'd0, 5'd0, 5'd6, 1, 0, 32'h0, 1, 0);
        mem_rd = 5'd0; mem_result = 32'hFFFF; rf_rd1 = 32'h3333;
        step();
        check("d_op1_x0", ex_op1, 32'h0);

        // EX and MEM both match: EX wins
        issue(32'h110, 5'd6, 5'd6, 5'd8, 1, 1, 32'h0, 1, 0);
        ex_result = 32'h55; mem_rd = 5'd6; mem_reg_write = 1; mem_result = 32'h66;
        rf_rd1 = 32'hDEAD; rf_rd2 = 32'hDEAD;
        step();
        check("e_op1", ex_op1, 32'h55);
        check("e_op2", ex_op2, 32'h55);

        // Load-use: one bubble, then MEM supplies the load data
        mem_reg_write = 0;
        issue(32'h200, 5'd0, 5'd0, 5'd3, 0, 0, 32'h0, 1, 1);
        step();
        check("l_mr", ex_mem_read, 1);
        issue(32'h204, 5'd3, 5'd0, 5'd7, 1, 0, 32'h0, 1, 0);
        rf_rd1 = 32'h1111; ex_result = 32'h2222;
        #1;
        check("lu_ready", id_ready, 0);
        step();
        check("lu_bubble", ex_valid, 0);
        check("lu_cnt", stall_cnt, 1);
        mem_rd = 5'd3; mem_reg_write = 1; mem_result = 32'hBEEF;
        #1;
        check("lu_ready2", id_ready, 1);
        step();
        check("lu_valid", ex_valid, 1);
        check("lu_pc", ex_pc, 32'h204);
        check("lu_op1", ex_op1, 32'hBEEF);
        check("lu_cnt2", stall_cnt, 1);

        // Backpressure: hold for three cycles, then flush
        ex_ready = 0; mem_reg_write = 0;
        issue(32'h300, 5'd1, 5'd2, 5'd9, 1, 1, 32'h0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", id_ready, 0);
            step();
            check("bp_valid", ex_valid, 1);
            check("bp_pc", ex_pc, 32'h204);
            check("bp_op1", ex_op1, 32'hBEEF);
        end
        flush = 1;
        #1;
        check("fl_ready", id_ready, 1);
        step();
        check("fl_valid", ex_valid, 0);
        flush = 0; ex_ready = 1;

        // Flush together with a load-use hazard: no bubble counted
        issue(32'h400, 5'd0, 5'd0, 5'd3, 0, 0, 32'h0, 1, 1);
        step();
        issue(32'h404, 5'd0, 5'd3, 5'd7, 0, 1, 32'h0, 1, 0);
        flush = 1;
        #1;
        check("fh_ready", id_ready, 1);
        step();
        check("fh_valid", ex_valid, 0);
        check("fh_cnt", stall_cnt, 1);
        flush = 0;

        // Saturation of the 4-bit bubble counter
        exp_cnt = 1;
        for (int i = 0; i < 20; i++) begin
            issue(32'h800, 5'd0, 5'd0, 5'd3, 0, 0, 32'h0, 1, 1);
            step();
            issue(32'h804, 5'd3, 5'd0, 5'd7, 1, 0, 32'h0, 1, 0);
            step();
            exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
            check("sat_cnt", stall_cnt, exp_cnt);
        end

        // Asynchronous reset while an instruction is held
        issue(32'h500, 5'd0, 5'd0, 5'd10, 0, 0, 32'h77, 1, 0);
        step();
        check("r_valid_pre", ex_valid, 1);
        ex_ready = 0;
        #2 rst_n = 0;
        #1;
        check("r_valid", ex_valid, 0);
        check("r_pc", ex_pc, 0);
        check("r_imm", ex_imm, 0);
        check("r_rd", ex_rd, 0);
        check("r_rw", ex_reg_write, 0);
        check("r_cnt", stall_cnt, 0);
        #1 rst_n = 1;
        ex_ready = 1;
        issue(32'h600, 5'd0, 5'd0, 5'd11, 0, 0, 32'h0, 1, 0);
        step();
        check("r_first_valid", ex_valid, 1);
        check("r_first_pc", ex_pc, 32'h600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
